// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Classifies presses of a debounced button into one-cycle event pulses:
//   short press, long press or double click, at most one per gesture.
//   A prescaler divides clk down to a timer tick; a small timer measures
//   hold and release-gap durations in ticks.
//
// Optional build macro:
//   HOLD_REPEAT_EN - while long-held, emit repeat_pulse every REPEAT_MS ticks.
//                    Without it repeat_pulse is tied low and LONG_HELD is untimed.
//
// Parameters:
//   TICK_DIV  - clk cycles per timer tick (>= 2)
//   LONG_MS   - hold ticks that qualify as a long press (>= 2)
//   DCLICK_MS - max release gap in ticks for a double click (>= 2)
//   REPEAT_MS - auto-repeat period in ticks (HOLD_REPEAT_EN only)
//
// Ports:
//   clk          - system clock
//   rst          - synchronous active-high reset
//   db           - debounced button level, 1 = pressed
//   short_press  - pulse: single press released before LONG_MS, no second press
//   long_press   - pulse: button held for LONG_MS
//   double_click - pulse: second press released
//   repeat_pulse - pulse: auto-repeat while long-held
//   busy         - high whenever a gesture is in progress
module button_event_decoder #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DCLICK_MS = 300,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic db,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic busy
);

    localparam int unsigned MAX_A   = (LONG_MS > DCLICK_MS) ? LONG_MS : DCLICK_MS;
    localparam int unsigned MAX_LIM = (MAX_A > REPEAT_MS) ? MAX_A : REPEAT_MS;
    localparam int unsigned TW      = $clog2(MAX_LIM) + 1;
    localparam int unsigned PW      = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          db_q;
    logic          rise, fall, tick;
    logic          timed, clear;
    logic          short_d, long_d, dclick_d;
`ifdef HOLD_REPEAT_EN
    logic          rep_d;
`endif

    assign rise = db & ~db_q;
    assign fall = ~db & db_q;
    assign tick = (presc_q == PW'(TICK_DIV - 1));

    // Next-state, pulse decisions and timer next value
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        dclick_d = 1'b0;
`ifdef HOLD_REPEAT_EN
        rep_d    = 1'b0;
`endif
        timed    = 1'b0;
        clear    = 1'b0;
        presc_d  = presc_q;
        timer_d  = timer_q;

        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESSED;
            end
            PRESSED: begin
                timed = 1'b1;
                // Release takes priority over a coincident long-press expiry
                if (fall) begin
                    state_d = WAIT_SECOND;
                end else if (tick && timer_q == TW'(LONG_MS - 1)) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_d = IDLE;
                end
`ifdef HOLD_REPEAT_EN
                else begin
                    timed = 1'b1;
                    if (tick && timer_q == TW'(REPEAT_MS - 1)) begin
                        rep_d = 1'b1;
                        clear = 1'b1;
                    end
                end
`endif
            end
            WAIT_SECOND: begin
                timed = 1'b1;
                // A second press on the expiry edge still counts as a double click
                if (rise) begin
                    state_d = SECOND_PRESSED;
                end else if (tick && timer_q == TW'(DCLICK_MS - 1)) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            SECOND_PRESSED: begin
                if (fall) begin
                    state_d  = IDLE;
                    dclick_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timer restarts on every transition and idles at zero in untimed states
        if (clear || !timed || state_d != state_q) begin
            presc_d = '0;
            timer_d = '0;
        end else if (tick) begin
            presc_d = '0;
            timer_d = timer_q + TW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State, timer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            timer_q      <= '0;
            db_q         <= 1'b1;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            timer_q      <= timer_d;
            db_q         <= db;
            short_press  <= short_d;
            long_press   <= long_d;
            double_click <= dclick_d;
            busy         <= (state_d != IDLE);
        end
    end

`ifdef HOLD_REPEAT_EN
    // Auto-repeat pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= rep_d;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
